// File: rtl/cpu_pkg.sv
// Shared load-path types: RISC-V load funct3 codes, load-unit FSM states and size helpers.
// Pure declarations; no timing or flow control lives here.
package cpu_pkg;

  localparam int WORD_BYTES = 4;

  typedef enum logic [2:0] {
    LB  = 3'b000,
    LH  = 3'b001,
    LW  = 3'b010,
    LBU = 3'b100,
    LHU = 3'b101
  } load_funct3_e;

  typedef enum logic [2:0] {
    IDLE,
    REQ0,
    WAIT0,
    REQ1,
    WAIT1,
    RESP
  } lau_state_e;

  function automatic logic funct3_legal(input logic [2:0] f);
    case (f)
      LB, LH, LW, LBU, LHU: return 1'b1;
      default:              return 1'b0;
    endcase
  endfunction

  // Low two funct3 bits encode the access size for every legal load.
  function automatic logic [2:0] load_size(input logic [2:0] f);
    case (f[1:0])
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic crosses_word(input logic [1:0] off, input logic [2:0] size);
    return ({1'b0, off} + size) > 3'(WORD_BYTES);
  endfunction

endpackage

// File: rtl/load_lane_merge.sv
// Combinational byte-lane merge of two little-endian words plus sign/zero extension.
// Zero latency; no flow control.
module load_lane_merge
  import cpu_pkg::*;
(
  input  logic [31:0] lo,
  input  logic [31:0] hi,
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [63:0] shifted;
  logic        unused_upper;

  assign shifted      = {hi, lo} >> {off, 3'b000};
  assign unused_upper = ^shifted[63:32];

  always_comb begin
    data = '0;
    case (funct3)
      LB:      data = {{24{shifted[7]}}, shifted[7:0]};
      LH:      data = {{16{shifted[15]}}, shifted[15:0]};
      LW:      data = shifted[31:0];
      LBU:     data = {24'b0, shifted[7:0]};
      LHU:     data = {16'b0, shifted[15:0]};
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/load_align_unit.sv
// Load stage: one or two word reads, lane merge, extension. Latency 3 (aligned), 5 (split), 1 (illegal).
// One request in flight; stalls in REQx on mem_req_ready and in RESP on rsp_ready.
module load_align_unit
  import cpu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [2:0]        req_funct3,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_rsp_valid,
  input  logic [31:0]       mem_rsp_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_data,
  output logic              rsp_err
);

  lau_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] word_base;
  logic [2:0]        funct3_q;
  logic              split_q;
  logic [31:0]       lo_q, hi_q;
  logic [31:0]       lo_in, hi_in;
  logic [31:0]       merged;

  // Merge straight from the bus on the final response beat so the result lands on RESP entry.
  assign lo_in = (state_q == WAIT0) ? mem_rsp_data : lo_q;
  assign hi_in = (state_q == WAIT1) ? mem_rsp_data : hi_q;

  load_lane_merge u_merge (
    .lo     (lo_in),
    .hi     (hi_in),
    .off    (addr_q[1:0]),
    .funct3 (funct3_q),
    .data   (merged)
  );

  assign word_base = {addr_q[ADDR_W-1:2], 2'b00};

  always_comb begin
    state_d       = state_q;
    req_ready     = (state_q == IDLE);
    mem_req_valid = (state_q == REQ0) || (state_q == REQ1);
    rsp_valid     = (state_q == RESP);
    mem_addr      = (state_q == REQ1) ? word_base + ADDR_W'(WORD_BYTES) : word_base;
    case (state_q)
      IDLE:  if (req_valid) state_d = funct3_legal(req_funct3) ? REQ0 : RESP;
      REQ0:  if (mem_req_ready) state_d = WAIT0;
      WAIT0: if (mem_rsp_valid) state_d = split_q ? REQ1 : RESP;
      REQ1:  if (mem_req_ready) state_d = WAIT1;
      WAIT1: if (mem_rsp_valid) state_d = RESP;
      RESP:  if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      funct3_q <= '0;
      split_q  <= 1'b0;
      lo_q     <= '0;
      hi_q     <= '0;
      rsp_data <= '0;
      rsp_err  <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            addr_q   <= req_addr;
            funct3_q <= req_funct3;
            split_q  <= crosses_word(req_addr[1:0], load_size(req_funct3));
            if (!funct3_legal(req_funct3)) begin
              rsp_data <= '0;
              rsp_err  <= 1'b1;
            end
          end
        end
        WAIT0: begin
          if (mem_rsp_valid) begin
            lo_q <= mem_rsp_data;
            if (!split_q) begin
              rsp_data <= merged;
              rsp_err  <= 1'b0;
            end
          end
        end
        WAIT1: begin
          if (mem_rsp_valid) begin
            hi_q     <= mem_rsp_data;
            rsp_data <= merged;
            rsp_err  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_load_align_unit.sv
// Scoreboard bench: byte-level memory model predicts load results, word addresses and latency.
module tb_load_align_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready;
  logic [31:0] req_addr;
  logic [2:0]  req_funct3;
  logic        mem_req_valid, mem_req_ready;
  logic [31:0] mem_addr;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_err;

  always #5 clk = ~clk;

  load_align_unit #(.ADDR_W(32)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_addr      (req_addr),
    .req_funct3    (req_funct3),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_addr      (mem_addr),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_data  (mem_rsp_data),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_data      (rsp_data),
    .rsp_err       (rsp_err)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] mem [logic [31:0]];
  logic [31:0] exp_data_q[$];
  logic        exp_err_q[$];
  int          exp_lat_q[$];
  int          acc_q[$];
  logic [31:0] exp_maddr_q[$];

  bit zero_wait = 1'b1;
  bit rand_mode = 1'b0;
  int stall_cnt = 0;
  int hold_cnt  = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    if (mem.exists(w)) return mem[w];
    return (w * 32'h9E3779B1) ^ 32'hA5C30F1E;
  endfunction

  function automatic logic [7:0] byte_at(input logic [31:0] a);
    logic [31:0] s;
    s = mem_word(a) >> (8 * a[1:0]);
    return s[7:0];
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_req_ready"},     32'(req_ready),     32'd1);
    chk({tag, "_mem_req_valid"}, 32'(mem_req_valid), 32'd0);
    chk({tag, "_mem_addr"},      mem_addr,           32'd0);
    chk({tag, "_rsp_valid"},     32'(rsp_valid),     32'd0);
    chk({tag, "_rsp_data"},      rsp_data,           32'd0);
    chk({tag, "_rsp_err"},       32'(rsp_err),       32'd0);
  endtask

  // Reference: assemble the loaded value byte by byte from memory, then extend.
  task automatic issue(input logic [31:0] a, input logic [2:0] f3);
    int          size;
    bit          legal, accepted;
    logic [31:0] v, w0, w1, last;
    legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
    size  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    v = '0;
    w0 = {a[31:2], 2'b00};
    last = a + 32'(size) - 32'd1;
    w1 = {last[31:2], 2'b00};
    if (legal) begin
      for (int i = 0; i < size; i++) v |= 32'(byte_at(a + 32'(i))) << (8 * i);
      if (!f3[2] && size == 1 && v[7])  v |= 32'hFFFFFF00;
      if (!f3[2] && size == 2 && v[15]) v |= 32'hFFFF0000;
      exp_maddr_q.push_back(w0);
      if (w1 != w0) exp_maddr_q.push_back(w1);
    end
    exp_data_q.push_back(v);
    exp_err_q.push_back(!legal);
    exp_lat_q.push_back(!zero_wait ? 0 : !legal ? 1 : (w1 != w0) ? 5 : 3);
    req_valid  = 1'b1;
    req_addr   = a;
    req_funct3 = f3;
    accepted   = 1'b0;
    for (int n = 0; n < 1000 && !accepted; n++) begin
      @(negedge clk);
      if (req_ready) begin
        accepted = 1'b1;
        acc_q.push_back(cyc + 1);
      end
    end
    if (!accepted) begin
      checks++;
      errors++;
      $display("FAIL req_accept: no acceptance within 1000 cycles for addr %h", a);
    end
    @(posedge clk);
    #1;
    req_valid  = 1'b0;
    req_addr   = $urandom;
    req_funct3 = 3'($urandom);
  endtask

  task automatic drain();
    for (int n = 0; n < 3000 && exp_data_q.size() > 0; n++) @(negedge clk);
    if (exp_data_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d responses outstanding, required 0", exp_data_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  // Memory side: checks request addresses, answers one cycle after each accepted read.
  initial begin
    bit          hs, stalled;
    logic [31:0] a, last_a;
    stalled       = 1'b0;
    last_a        = '0;
    mem_req_ready = 1'b1;
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = '0;
    rsp_ready     = 1'b1;
    forever begin
      @(negedge clk);
      hs = rst_n && mem_req_valid && mem_req_ready;
      a  = mem_addr;
      if (hs) begin
        if (exp_maddr_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL mem_req_unexpected: got read of %h, required none", a);
        end else begin
          chk("mem_addr", a, exp_maddr_q.pop_front());
        end
      end
      if (rst_n && mem_req_valid && !mem_req_ready) begin
        if (stalled) chk("mem_addr_stable", a, last_a);
        stalled = 1'b1;
        last_a  = a;
      end else begin
        stalled = 1'b0;
      end
      if (stall_cnt > 0 && mem_req_valid) stall_cnt--;
      if (hold_cnt > 0 && rsp_valid) hold_cnt--;
      @(posedge clk);
      #1;
      mem_rsp_valid = hs || (rand_mode && $urandom_range(3) == 0);
      mem_rsp_data  = hs ? mem_word(a) : $urandom;
      mem_req_ready = (stall_cnt == 0) && (!rand_mode || $urandom_range(3) != 0);
      rsp_ready     = (hold_cnt == 0) && (!rand_mode || $urandom_range(2) != 0);
    end
  end

  // Response monitor.
  initial begin
    bit          seen;
    int          first_cyc, acc, lat;
    logic [31:0] held;
    seen = 1'b0;
    first_cyc = 0;
    held = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        seen = 1'b0;
      end else if (rsp_valid) begin
        if (!seen) begin
          seen      = 1'b1;
          first_cyc = cyc;
          held      = rsp_data;
        end else begin
          chk("rsp_data_stable", rsp_data, held);
        end
        chk("req_ready_busy", 32'(req_ready), 32'd0);
        if (rsp_ready) begin
          if (exp_data_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rsp_unexpected: got data %h, required no response", rsp_data);
          end else begin
            chk("rsp_data", rsp_data, exp_data_q.pop_front());
            chk("rsp_err", 32'(rsp_err), 32'(exp_err_q.pop_front()));
            lat = exp_lat_q.pop_front();
            acc = acc_q.pop_front();
            if (lat > 0) chk("latency", 32'(first_cyc - acc + 1), 32'(lat));
          end
          seen = 1'b0;
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    bit found;
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_addr   = '0;
    req_funct3 = '0;
    #12;
    check_reset("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    mem[32'h100] = 32'hDEADBEEF;
    issue(32'h100, 3'd2);
    drain();
    mem[32'h100] = 32'h80112233;
    issue(32'h103, 3'd0);
    issue(32'h103, 3'd4);
    drain();
    mem[32'h200] = 32'h11223344;
    mem[32'h204] = 32'h556677AA;
    issue(32'h203, 3'd1);
    issue(32'h203, 3'd5);
    drain();
    mem[32'h300] = 32'h44332211;
    mem[32'h304] = 32'h88776655;
    issue(32'h301, 3'd2);
    drain();
    issue(32'h40, 3'd3);
    issue(32'h44, 3'd7);
    drain();
    issue(32'hFFFFFFFE, 3'd2);
    issue(32'hFFFFFFFF, 3'd1);
    issue(32'hFFFFFFFD, 3'd4);
    drain();

    zero_wait = 1'b0;
    stall_cnt = 4;
    @(posedge clk);
    #2;
    issue(32'h502, 3'd2);
    drain();
    hold_cnt = 3;
    @(posedge clk);
    #2;
    issue(32'h507, 3'd1);
    drain();
    zero_wait = 1'b1;

    issue(32'h600, 3'd2);
    found = 1'b0;
    for (int n = 0; n < 100 && !found; n++) begin
      @(negedge clk);
      if (mem_req_valid && mem_req_ready) found = 1'b1;
    end
    chk("reset_reached_wait0", 32'(found), 32'd1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset("mid_reset");
    exp_data_q.delete();
    exp_err_q.delete();
    exp_lat_q.delete();
    acc_q.delete();
    exp_maddr_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int k = 0; k < 60; k++) begin
      issue($urandom, 3'($urandom_range(7)));
    end
    drain();
    rand_mode = 1'b1;
    zero_wait = 1'b0;
    for (int k = 0; k < 150; k++) begin
      issue((k % 10 == 0) ? (32'hFFFFFFFC | 32'($urandom_range(3))) : $urandom,
            3'($urandom_range(7)));
      repeat ($urandom_range(2)) begin
        @(posedge clk);
        #1;
      end
    end
    drain();
    rand_mode = 1'b0;
    repeat (3) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
